// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: session controller feeding a 101 Moore detector and counting its matches.
// Optional SEQ_CTRL_FIRSTIDX_EN adds first_vld_o/first_idx_o (index of the bit completing the first match).
module seq_detect_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cfg_window_i,
    input  logic [CNT_W-1:0] cfg_limit_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    output logic             in_ready_o,
    output logic             det_rst_o,
    output logic             det_x_o,
    input  logic             det_z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       status_o,
    output logic [CNT_W-1:0] match_cnt_o,
`ifdef SEQ_CTRL_FIRSTIDX_EN
    output logic             first_vld_o,
    output logic [CNT_W-1:0] first_idx_o,
`endif
    output logic [CNT_W-1:0] bits_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [2:0] ST_NONE = 3'd0, ST_WIN = 3'd1, ST_LIM = 3'd2, ST_ABT = 3'd3, ST_UND = 3'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] win_q, win_d, lim_q, lim_d;
    logic [CNT_W-1:0] match_q, match_d, bits_q, bits_d;
    logic [2:0]       status_q, status_d;
    logic             run, drain, stop_lim, accept, cnt_z;
    logic [CNT_W-1:0] bits_inc;
`ifdef SEQ_CTRL_FIRSTIDX_EN
    logic             fv_q, fv_d;
    logic [CNT_W-1:0] fi_q, fi_d;
    assign first_vld_o = fv_q;
    assign first_idx_o = fi_q;
`endif

    assign run      = state_q == RUN;
    assign drain    = state_q == DRAIN;
    assign stop_lim = det_z_i && lim_q != '0 && (match_q + CNT_W'(1)) == lim_q;
    assign in_ready_o = run & ~abort_i & ~stop_lim;
    assign accept   = in_ready_o & in_valid_i;
    assign bits_inc = bits_q + CNT_W'(1);
    // det_z reflects the previous cycle's bit; an abort in RUN discards it
    assign cnt_z    = det_z_i & ((run & ~abort_i) | drain);

    assign det_rst_o   = state_q == IDLE || state_q == DONE;
    assign det_x_o     = run & in_bit_i;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign status_o    = status_q;
    assign match_cnt_o = match_q;
    assign bits_cnt_o  = bits_q;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        lim_d    = lim_q;
        match_d  = match_q;
        bits_d   = bits_q;
        status_d = status_q;
`ifdef SEQ_CTRL_FIRSTIDX_EN
        fv_d = fv_q;
        fi_d = fi_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                win_d    = cfg_window_i;
                lim_d    = cfg_limit_i;
                match_d  = '0;
                bits_d   = '0;
                status_d = cfg_window_i == '0 ? ST_WIN : ST_NONE;
                state_d  = cfg_window_i == '0 ? DONE : RUN;
`ifdef SEQ_CTRL_FIRSTIDX_EN
                fv_d = 1'b0;
                fi_d = '0;
`endif
            end
            RUN: begin
                if (accept) bits_d = bits_inc;
                if (abort_i) begin
                    status_d = ST_ABT;
                    state_d  = DONE;
                end else if (stop_lim) begin
                    status_d = ST_LIM;
                    state_d  = DONE;
                end else if (!in_valid_i) begin
                    status_d = ST_UND;
                    state_d  = DONE;
                end else if (bits_inc == win_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                status_d = abort_i ? ST_ABT : ST_WIN;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (cnt_z) match_d = match_q + CNT_W'(1);
`ifdef SEQ_CTRL_FIRSTIDX_EN
        if (cnt_z && !fv_q) begin
            fv_d = 1'b1;
            fi_d = bits_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            win_q    <= '0;
            lim_q    <= '0;
            match_q  <= '0;
            bits_q   <= '0;
            status_q <= ST_NONE;
`ifdef SEQ_CTRL_FIRSTIDX_EN
            fv_q <= 1'b0;
            fi_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            lim_q    <= lim_d;
            match_q  <= match_d;
            bits_q   <= bits_d;
            status_q <= status_d;
`ifdef SEQ_CTRL_FIRSTIDX_EN
            fv_q <= fv_d;
            fi_q <= fi_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: table-driven, hand-written and randomized checks of seq_detect_ctrl with a behavioural 101 detector.
module tb_seq_detect_ctrl;
    localparam int CNT_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
    logic [CNT_W-1:0] cfg_window = '0, cfg_limit = '0;
    logic in_ready, det_rst, det_x, det_z, busy, done;
    logic [2:0] status;
    logic [CNT_W-1:0] match_cnt, bits_cnt;
    logic first_vld;
    logic [CNT_W-1:0] first_idx;
    logic [2:0] dh = 3'b000;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Overlapping 101 Moore detector: match when the last three bits seen are 1,0,1
    always_ff @(posedge clk) dh <= det_rst ? 3'b000 : {dh[1:0], det_x};
    assign det_z = dh == 3'b101;

    seq_detect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .cfg_window_i(cfg_window), .cfg_limit_i(cfg_limit),
        .in_valid_i(in_valid), .in_bit_i(in_bit), .in_ready_o(in_ready),
        .det_rst_o(det_rst), .det_x_o(det_x), .det_z_i(det_z),
        .busy_o(busy), .done_o(done), .status_o(status), .match_cnt_o(match_cnt),
`ifdef SEQ_CTRL_FIRSTIDX_EN
        .first_vld_o(first_vld), .first_idx_o(first_idx),
`endif
        .bits_cnt_o(bits_cnt)
    );
`ifndef SEQ_CTRL_FIRSTIDX_EN
    assign first_vld = 1'b0;
    assign first_idx = '0;
`endif

    typedef struct {
        int w; int l; logic [31:0] bits; int nvalid; int abrt; bit hold;
        int em; int eb; int es; int edc; int efi;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pat(input logic [31:0] b, input int j);
        if (j < 4) return 1'b0;
        return b[j-4] == 1'b1 && b[j-3] == 1'b0 && b[j-2] == 1'b1;
    endfunction

    // Reference: cycle j of RUN offers bit j; a match completed by bit j-1 is seen in cycle j
    task automatic model(input int w, l, input logic [31:0] b, input int nvalid, abrt,
                         output int em, eb, es, edc, efi);
        em = 0; efi = 0;
        if (w == 0) begin eb = 0; es = 1; edc = 1; return; end
        for (int j = 1; j <= w; j++) begin
            if (j == abrt) begin eb = j - 1; es = 3; edc = j + 1; return; end
            if (pat(b, j)) begin
                em++;
                if (efi == 0) efi = j - 1;
                if (l != 0 && em == l) begin eb = j - 1; es = 2; edc = j + 1; return; end
            end
            if (j > nvalid) begin eb = j - 1; es = 4; edc = j + 1; return; end
        end
        if (pat(b, w + 1)) begin
            em++;
            if (efi == 0) efi = w;
        end
        eb = w; es = (abrt == w + 1) ? 3 : 1; edc = w + 2;
    endtask

    task automatic run_session(input int w, l, input logic [31:0] b, input int nvalid, abrt,
                               input bit hold, output int dcyc, output logic dr, bz);
        @(posedge clk); #1;
        start = 1'b1; cfg_window = CNT_W'(w); cfg_limit = CNT_W'(l);
        abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        @(posedge clk); #1;
        start = hold; dcyc = 0; dr = 1'b0; bz = 1'b0;
        for (int j = 1; j <= w + 4 && dcyc == 0; j++) begin
            in_valid = j <= nvalid;
            in_bit = b[j-1];
            abort = j == abrt;
            @(negedge clk);
            if (done) begin dcyc = j; dr = det_rst; bz = busy; end
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; abort = 1'b0; in_bit = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
    endtask

    task automatic check_session(input string p, input int em, eb, es, edc, efi,
                                 input int dcyc, input logic dr, bz);
        chk({p, "_done_cycle"}, dcyc, edc);
        chk({p, "_status"}, {29'b0, status}, es);
        chk({p, "_match_cnt"}, {24'b0, match_cnt}, em);
        chk({p, "_bits_cnt"}, {24'b0, bits_cnt}, eb);
        chk({p, "_det_rst_in_done"}, {31'b0, dr}, 1);
        chk({p, "_busy_in_done"}, {31'b0, bz}, 1);
`ifdef SEQ_CTRL_FIRSTIDX_EN
        chk({p, "_first_vld"}, {31'b0, first_vld}, efi != 0);
        chk({p, "_first_idx"}, {24'b0, first_idx}, efi);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int dcyc, em, eb, es, edc, efi, w, l, nv, ab;
        logic dr, bz;
        logic [31:0] b;
        bit saw_done;
        //          w   l  bits        nvalid abrt hold  em eb es edc efi
        tbl[0] = '{ 8,  0, 32'hB5,    255,   0,   0,    3, 8, 1, 10, 3};
        tbl[1] = '{10,  2, 32'h155,   255,   0,   0,    2, 5, 2,  7, 3};
        tbl[2] = '{ 6,  0, 32'hD,       4,   0,   0,    1, 4, 4,  6, 3};
        tbl[3] = '{20,  0, 32'h155,   255,   8,   1,    2, 7, 3,  9, 3};
        tbl[4] = '{ 0,  0, 32'h0,     255,   0,   0,    0, 0, 1,  1, 0};
        tbl[5] = '{ 3,  1, 32'h5,     255,   0,   0,    1, 3, 1,  5, 3};
        tbl[6] = '{ 5,  0, 32'h15,    255,   6,   0,    2, 5, 3,  7, 3};
        tbl[7] = '{ 6,  1, 32'hD,     255,   0,   0,    1, 3, 2,  5, 3};
        tbl[8] = '{ 2,  0, 32'h3,     255,   0,   0,    0, 2, 1,  4, 0};

        #3;
        chk("rst_det_rst", {31'b0, det_rst}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_det_x", {31'b0, det_x}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_status", {29'b0, status}, 0);
        chk("rst_counts", {16'b0, match_cnt, bits_cnt}, 0);
        #20 rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_session(tbl[i].w, tbl[i].l, tbl[i].bits, tbl[i].nvalid, tbl[i].abrt, tbl[i].hold, dcyc, dr, bz);
            check_session($sformatf("tbl%0d", i), tbl[i].em, tbl[i].eb, tbl[i].es, tbl[i].edc, tbl[i].efi, dcyc, dr, bz);
        end

        // abort in IDLE must not start anything
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", {31'b0, busy}, 0);
        @(posedge clk); #1 abort = 1'b0;

        // limit stop: in_ready drops in the cycle the second match appears
        @(posedge clk); #1 start = 1'b1; cfg_window = 10; cfg_limit = 2;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            in_bit = j[0];
            @(negedge clk);
            if (j == 5) chk("lim_ready_before", {31'b0, in_ready}, 1);
            if (j == 6) chk("lim_ready_stop", {31'b0, in_ready}, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("lim_done", {31'b0, done}, 1);

        // abort mid-RUN: in_ready low that cycle, detector reset in DONE
        @(posedge clk); #1 start = 1'b1; cfg_window = 20; cfg_limit = 0;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1 abort = 1'b1;
        #1 chk("abort_ready", {31'b0, in_ready}, 0);
        @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_done_det_rst", {30'b0, done, det_rst}, 3);
        chk("abort_status", {29'b0, status}, 3);

        // reset mid-RUN clears everything immediately, no done pulse
        @(posedge clk); #1 start = 1'b1; cfg_window = 20;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            in_bit = j[0];
            @(posedge clk); #1;
        end
        chk("pre_rst_bits", {24'b0, bits_cnt}, 5);
        chk("pre_rst_match", {24'b0, match_cnt}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_det_rst", {30'b0, busy, det_rst}, 1);
        chk("mid_rst_counts", {16'b0, match_cnt, bits_cnt}, 0);
        saw_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("mid_rst_no_done", {31'b0, saw_done}, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        run_session(tbl[0].w, tbl[0].l, tbl[0].bits, tbl[0].nvalid, tbl[0].abrt, 0, dcyc, dr, bz);
        check_session("post_rst", tbl[0].em, tbl[0].eb, tbl[0].es, tbl[0].edc, tbl[0].efi, dcyc, dr, bz);

        for (int k = 0; k < 60; k++) begin
            w = $urandom_range(0, 24);
            l = $urandom_range(0, 3);
            b = $urandom;
            nv = ($urandom_range(0, 9) < 7) ? 255 : $urandom_range(1, w + 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w + 2) : 0;
            model(w, l, b, nv, ab, em, eb, es, edc, efi);
            run_session(w, l, b, nv, ab, $urandom_range(0, 1), dcyc, dr, bz);
            check_session($sformatf("rnd%0d", k), em, eb, es, edc, efi, dcyc, dr, bz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
